// File: rtl/mem_bus_trace.sv
// mem_bus_trace: bus snooper that counts accesses and traces in-window writes into a FWFT FIFO
module mem_bus_trace #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 16,
    parameter logic [ADDR_WIDTH-1:0] WIN_BASE = ADDR_WIDTH'('h0100000),
    parameter logic [ADDR_WIDTH-1:0] WIN_LIMIT = ADDR_WIDTH'('h010000F)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ENABLE,
    input  logic [ADDR_WIDTH-1:0]      BUS_ADDR,
    input  logic [DATA_WIDTH-1:0]      BUS_DATA,
    input  logic                       BUS_READ,
    input  logic                       BUS_WRITE,
    output logic                       TRACE_VALID,
    output logic [ADDR_WIDTH-1:0]      TRACE_ADDR,
    output logic [DATA_WIDTH-1:0]      TRACE_DATA,
    input  logic                       TRACE_POP,
    output logic [$clog2(DEPTH):0]     TRACE_LEVEL,
    output logic                       OVERFLOW,
    output logic [31:0]                WR_COUNT,
    output logic [31:0]                RD_COUNT,
    output logic [15:0]                ERR_COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

    state_t                state, state_nxt;
    logic                  rd_start, wr_start, err_start;
    logic                  in_window, push_req, push_ok, pop_ok, full, fwd;
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [LW-1:0]         level_nxt;
    logic [ADDR_WIDTH-1:0] head_addr_nxt;
    logic [DATA_WIDTH-1:0] head_data_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    // bus state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nxt;
    end

    // next state straight from the strobes; an access starts only on a state change
    always_comb begin
        state_nxt = IDLE;
        case ({BUS_READ, BUS_WRITE})
            2'b10:   state_nxt = RD;
            2'b01:   state_nxt = WR;
            2'b11:   state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
        rd_start  = (state_nxt == RD) && (state != RD);
        wr_start  = (state_nxt == WR) && (state != WR);
        err_start = (state_nxt == ERR) && (state != ERR);
    end

    // push/pop decisions and the head entry that will be visible after this edge
    always_comb begin
        in_window  = (BUS_ADDR >= WIN_BASE) && (BUS_ADDR <= WIN_LIMIT);
        push_req   = wr_start && ENABLE && in_window;
        pop_ok     = TRACE_POP && TRACE_VALID;
        full       = TRACE_LEVEL == LW'(DEPTH);
        push_ok    = push_req && (!full || pop_ok);
        rd_ptr_nxt = rd_ptr + PW'(pop_ok);
        level_nxt  = TRACE_LEVEL + LW'(push_ok) - LW'(pop_ok);
        fwd        = push_ok && (rd_ptr_nxt == wr_ptr);
        head_addr_nxt = (level_nxt == '0) ? '0 : fwd ? BUS_ADDR : mem_addr[rd_ptr_nxt];
        head_data_nxt = (level_nxt == '0) ? '0 : fwd ? BUS_DATA : mem_data[rd_ptr_nxt];
    end

    // FIFO storage; contents need no reset because level gates visibility
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= BUS_ADDR;
            mem_data[wr_ptr] <= BUS_DATA;
        end
    end

    // FIFO pointers, level, registered head and sticky overflow
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            TRACE_LEVEL <= '0;
            TRACE_VALID <= 1'b0;
            TRACE_ADDR  <= '0;
            TRACE_DATA  <= '0;
            OVERFLOW    <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push_ok);
            rd_ptr      <= rd_ptr_nxt;
            TRACE_LEVEL <= level_nxt;
            TRACE_VALID <= level_nxt != '0;
            TRACE_ADDR  <= head_addr_nxt;
            TRACE_DATA  <= head_data_nxt;
            OVERFLOW    <= OVERFLOW || (push_req && !push_ok);
        end
    end

    // access counters; reads and writes wrap, errors saturate
    always_ff @(posedge CLK) begin
        if (RST) begin
            WR_COUNT  <= '0;
            RD_COUNT  <= '0;
            ERR_COUNT <= '0;
        end else begin
            WR_COUNT  <= WR_COUNT + 32'(wr_start);
            RD_COUNT  <= RD_COUNT + 32'(rd_start);
            ERR_COUNT <= (err_start && ERR_COUNT != 16'hFFFF) ? ERR_COUNT + 16'd1 : ERR_COUNT;
        end
    end
endmodule

// File: tb/tb_mem_bus_trace.sv
// tb_mem_bus_trace: directed and random checks of mem_bus_trace against a queue-based model
module tb_mem_bus_trace;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam logic [AW-1:0] BASE = 26'h0100000;
    localparam logic [AW-1:0] LIMIT = 26'h010000F;

    logic clk = 1'b0;
    logic rst, en, rd, wr, pop;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic valid, ovf;
    logic [AW-1:0] taddr;
    logic [DW-1:0] tdata;
    logic [4:0] level;
    logic [31:0] wrc, rdc;
    logic [15:0] errc;

    int vectors = 0;
    int miscompares = 0;

    logic [AW+DW-1:0] q[$];
    logic [31:0] m_wr, m_rd;
    logic [15:0] m_err;
    logic m_ovf;
    logic [1:0] m_prev;

    always #5 clk = ~clk;

    mem_bus_trace #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                    .WIN_BASE(BASE), .WIN_LIMIT(LIMIT)) dut (
        .CLK(clk), .RST(rst), .ENABLE(en), .BUS_ADDR(addr), .BUS_DATA(data),
        .BUS_READ(rd), .BUS_WRITE(wr), .TRACE_VALID(valid), .TRACE_ADDR(taddr),
        .TRACE_DATA(tdata), .TRACE_POP(pop), .TRACE_LEVEL(level), .OVERFLOW(ovf),
        .WR_COUNT(wrc), .RD_COUNT(rdc), .ERR_COUNT(errc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd = r;
        wr = w;
        addr = a;
        data = d;
    endtask

    task automatic model();
        logic [1:0] cur;
        logic start, pop_ok, push;
        if (rst) begin
            q.delete();
            m_wr = 0;
            m_rd = 0;
            m_err = 0;
            m_ovf = 0;
            m_prev = 2'b00;
            return;
        end
        cur = {rd, wr};
        start = (cur != 2'b00) && (cur != m_prev);
        pop_ok = pop && (q.size() != 0);
        if (start && cur == 2'b10) m_rd = m_rd + 1;
        if (start && cur == 2'b01) m_wr = m_wr + 1;
        if (start && cur == 2'b11 && m_err != 16'hFFFF) m_err = m_err + 1;
        push = start && cur == 2'b01 && en && addr >= BASE && addr <= LIMIT;
        if (push && q.size() == DEPTH && !pop_ok) begin
            m_ovf = 1;
            push = 0;
        end
        if (pop_ok) void'(q.pop_front());
        if (push) q.push_back({addr, data});
        m_prev = cur;
    endtask

    task automatic check_all();
        logic [AW+DW-1:0] h;
        chk("valid", valid, q.size() != 0);
        chk("level", level, q.size());
        chk("overflow", ovf, m_ovf);
        chk("wr_count", wrc, m_wr);
        chk("rd_count", rdc, m_rd);
        chk("err_count", errc, m_err);
        if (q.size() != 0) begin
            h = q[0];
            chk("head_addr", taddr, h[AW+DW-1:DW]);
            chk("head_data", tdata, h[DW-1:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1; en = 1; pop = 0;
        drive(0, 0, '0, '0);
        step();
        step();
        chk("rst_addr", taddr, 0);
        chk("rst_data", tdata, 0);
        rst = 0;
        repeat (10) step();

        drive(0, 1, 26'h0100003, 32'hDEADBEEF);
        step();
        chk("wr1_valid", valid, 1);
        chk("wr1_addr", taddr, 26'h0100003);
        chk("wr1_data", tdata, 32'hDEADBEEF);
        step();
        step();
        drive(0, 0, '0, '0);
        step();
        chk("wr1_count", wrc, 1);
        chk("wr1_level", level, 1);
        pop = 1;
        step();
        pop = 0;
        chk("pop_valid", valid, 0);
        chk("pop_level", level, 0);
        step();

        rst = 1; step(); rst = 0;
        drive(0, 1, 26'h00FFFFF, 32'h11); step();
        drive(0, 0, '0, '0); step();
        drive(0, 1, 26'h0100010, 32'h22); step();
        drive(0, 0, '0, '0); step();
        drive(1, 0, 26'h0100000, 32'h33); step();
        drive(0, 0, '0, '0); step();
        chk("out_wr_count", wrc, 2);
        chk("out_rd_count", rdc, 1);
        chk("out_level", level, 0);
        en = 0;
        drive(0, 1, 26'h0100005, 32'h44); step();
        drive(0, 0, '0, '0); step();
        chk("dis_level", level, 0);
        en = 1;

        rst = 1; step(); rst = 0;
        for (int i = 1; i <= 17; i++) begin
            drive(0, 1, BASE + AW'(i % 16), DW'(i)); step();
            drive(0, 0, '0, '0); step();
        end
        chk("full_level", level, 16);
        chk("full_ovf", ovf, 1);
        pop = 1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", tdata, DW'(i));
            step();
        end
        pop = 0;
        chk("drain_valid", valid, 0);

        rst = 1; step(); rst = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, BASE + AW'(i), DW'(100 + i)); step();
            drive(0, 0, '0, '0); step();
        end
        drive(0, 1, BASE, 32'd200);
        pop = 1;
        step();
        pop = 0;
        drive(0, 0, '0, '0);
        chk("pp_level", level, 16);
        chk("pp_ovf", ovf, 0);
        chk("pp_head", tdata, 101);
        step();

        drive(1, 1, BASE, 32'h55); step(); step();
        drive(0, 0, '0, '0); step();
        chk("err_count1", errc, 1);
        chk("err_level", level, 16);

        rst = 1; step(); rst = 0;
        drive(0, 1, BASE + 26'd2, 32'h66); step();
        chk("pre_rst_level", level, 1);
        rst = 1; step();
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_wr", wrc, 0);
        chk("mid_rst_addr", taddr, 0);
        chk("mid_rst_data", tdata, 0);
        rst = 0;
        drive(0, 0, '0, '0); step();
        chk("post_rst_level", level, 0);

        for (int i = 0; i < 600; i++) begin
            logic [2:0] k;
            k = 3'($urandom_range(0, 7));
            drive(k == 3'd5 || k == 3'd7, k == 3'd6 || k == 3'd7 || k < 3'd3,
                  BASE - AW'(2) + AW'($urandom_range(0, 19)), $urandom);
            if (k == 3'd0 && $urandom_range(0, 1) == 0) drive(0, 0, addr, data);
            en = $urandom_range(0, 7) != 0;
            pop = $urandom_range(0, 3) == 0;
            rst = $urandom_range(0, 199) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
